deinterleave_accumulator: RTL

Backward-direction counterpart of the rs/sweep-change interleaver. It accepts z lane values per beat over one junction's fo·p/z processing cycles. Each lane value is scattered into the left-side neuron it was read from, using the same sweepstart permutation. The block accumulates the fo contributions per neuron into p on-chip sums, then drains them in natural neuron order, z per beat. It sits between the junction's backprop datapath and the left-side delta memory.

---
 rtl/deinterleave_accumulator_if.sv | 36 +++
 rtl/deinterleave_accumulator.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/deinterleave_accumulator_if.sv
// deinterleave_accumulator_if
//   Bundles the two streaming handshakes of the deinterleave accumulator.
//   Lane input side: in_valid, in_ready, in_data (z lanes of W bits).
//   Drain output side: out_valid, out_ready, out_row, out_data (z lanes of AW bits).
//
//   Handshake rule (both sides): a beat transfers on a rising clk edge where
//   valid and ready are both high. The producer holds data stable while
//   valid is high and ready is low. Ready does not depend on valid.
//
//   Modports:
//     master - the environment: drives lane data and the drain ready.
//     slave  - the accumulator: accepts lane data and produces drain beats.
interface deinterleave_accumulator_if #(
    parameter int z  = 8,
    parameter int W  = 8,
    parameter int AW = 9,
    parameter int LS = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [W*z-1:0]    in_data;
    logic              out_valid;
    logic              out_ready;
    logic [LS-1:0]     out_row;
    logic [AW*z-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_row, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_row, out_data
    );
endinterface

// File: rtl/deinterleave_accumulator.sv
// deinterleave_accumulator
//   Backward counterpart of the sweep-change interleaver. Over fo sweeps of
//   p/z beats each, lane k of every beat is added into bank k at the row the
//   forward interleaver read it from: (chunk[k + z*sweep] + c_low) mod p/z.
//   After the last beat the p sums are drained in natural neuron order,
//   z lanes per beat (row r, lane k = neuron r*z + k).
//
//   Parameters: fo (sweeps, power of 2, >= 2), p (neurons), z (lanes),
//               W (signed lane input width), AW (signed accumulator width).
//   Ports:
//     clk        rising-edge clock
//     reset      asynchronous active-low reset
//     sweepstart permutation seed, chunk j = bits [j*LS +: LS]; latched on start
//     start      begin a junction; honoured only in IDLE
//     busy       high whenever the FSM is not IDLE
//     done       one-cycle pulse after the final drain beat
//     dbg_state  current FSM state (IDLE=0, ACCUM=1, DRAIN=2)
//     bus        slave side of deinterleave_accumulator_if (lane in / drain out)
//
//   Build option: define SATURATE_EN to clamp each per-lane add to the AW-bit
//   signed range; otherwise adds wrap modulo 2^AW.
module deinterleave_accumulator #(
    parameter int fo = 2,
    parameter int p  = 32,
    parameter int z  = 8,
    parameter int W  = 8,
    parameter int AW = W + $clog2(fo),
    localparam int LS = $clog2(p / z)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LS*fo*z-1:0]   sweepstart,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state,
    deinterleave_accumulator_if.slave bus
);
    localparam int RN  = p / z;
    localparam int CI  = $clog2(fo * p / z);
    localparam int SW  = ((AW > W) ? AW : W) + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic signed [SW-1:0] MAXV = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [SW-1:0] MINV = {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};

    logic [1:0]            state;
    logic [CI-1:0]         c;
    logic [LS-1:0]         r;
    logic [LS*fo*z-1:0]    seed;
    logic                  done_q;
    logic signed [AW-1:0]  acc [z][RN];
    logic [LS-1:0]         row_sel [z];
    logic [CI-LS-1:0]      sweep;
    logic                  last_beat;
    logic [AW*z-1:0]       out_data_c;

    // Add one sign-extended lane value to an accumulator in a width that
    // cannot overflow, then either clamp or wrap back to AW bits.
    function automatic logic signed [AW-1:0] add_lane(
        input logic signed [AW-1:0] a,
        input logic signed [W-1:0]  b
    );
        logic signed [SW-1:0] sum;
        sum = $signed({{(SW-AW){a[AW-1]}}, a}) + $signed({{(SW-W){b[W-1]}}, b});
`ifdef SATURATE_EN
        if (sum > MAXV) begin
            return MAXV[AW-1:0];
        end else if (sum < MINV) begin
            return MINV[AW-1:0];
        end else begin
            return sum[AW-1:0];
        end
`else
        return sum[AW-1:0];
`endif
    endfunction

    assign sweep     = c[CI-1:LS];
    assign last_beat = (c == CI'(fo * RN - 1));

    // Scatter row per lane; the LS-bit add wraps naturally mod p/z, so each
    // lane visits every row exactly once per sweep.
    always_comb begin
        for (int k = 0; k < z; k++) begin
            row_sel[k] = seed[(k + z * int'(sweep)) * LS +: LS] + c[LS-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            c      <= '0;
            r      <= '0;
            seed   <= '0;
            done_q <= 1'b0;
            for (int k = 0; k < z; k++) begin
                for (int j = 0; j < RN; j++) begin
                    acc[k][j] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        seed  <= sweepstart;
                        c     <= '0;
                        r     <= '0;
                        state <= S_ACCUM;
                        for (int k = 0; k < z; k++) begin
                            for (int j = 0; j < RN; j++) begin
                                acc[k][j] <= '0;
                            end
                        end
                    end
                end
                S_ACCUM: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < z; k++) begin
                            acc[k][row_sel[k]] <= add_lane(acc[k][row_sel[k]],
                                                           bus.in_data[k*W +: W]);
                        end
                        // c wraps to 0 after the last beat since fo*p/z is a power of 2.
                        c <= c + 1'b1;
                        if (last_beat) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        if (r == LS'(RN - 1)) begin
                            r      <= '0;
                            done_q <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            r <= r + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Drain data is a select of registered sums by the registered row index,
    // so it is stable for as long as the row is held; zero outside DRAIN.
    always_comb begin
        out_data_c = '0;
        if (state == S_DRAIN) begin
            for (int k = 0; k < z; k++) begin
                out_data_c[k*AW +: AW] = acc[k][r];
            end
        end
    end

    assign bus.in_ready  = (state == S_ACCUM);
    assign bus.out_valid = (state == S_DRAIN);
    assign bus.out_row   = r;
    assign bus.out_data  = out_data_c;
    assign busy          = (state != S_IDLE);
    assign done          = done_q;
    assign dbg_state     = state;
endmodule
